// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// dma_pkg : shared types, constants and the priority rotation helper for the
//           DMA channel arbiter.
// Revision: 1.0
// ============================================================================
package dma_pkg;

    localparam int         DMA_CHANNELS           = 4;
    localparam logic [7:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HLDA = 2'd1,
        GRANT     = 2'd2
    } arbState_t;

    // Served channel drops to the lowest slot; its successor becomes highest.
    function automatic logic [7:0] rotateOrder(input logic [1:0] chan);
        return {chan, chan + 2'd3, chan + 2'd2, chan + 2'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// dma_priority_arbiter_if : pin/command/status bundle of the DMA arbiter.
//           SOFTWARE_REQUEST_EN adds the software request write port.
// Revision: 1.0
// ============================================================================
interface dma_priority_arbiter_if;
    import dma_pkg::*;

    logic [DMA_CHANNELS-1:0] DREQ;
    logic                    dreqSenseLow;
    logic                    rotatingPriority;
    logic                    controllerDisable;
    logic [DMA_CHANNELS-1:0] maskReg;
    logic                    HLDA;
    logic                    serviceDone;
    logic                    HRQ;
    logic [DMA_CHANNELS-1:0] DACK;
    logic [1:0]              activeChannel;
    logic                    grantValid;
    logic [7:0]              priorityOrder;
    logic [DMA_CHANNELS-1:0] requestStatus;
`ifdef SOFTWARE_REQUEST_EN
    logic                    softReqWrite;
    logic [2:0]              softReqData;
`endif

    modport master (
        output DREQ, dreqSenseLow, rotatingPriority, controllerDisable,
        output maskReg, HLDA, serviceDone,
`ifdef SOFTWARE_REQUEST_EN
        output softReqWrite, softReqData,
`endif
        input  HRQ, DACK, activeChannel, grantValid, priorityOrder, requestStatus
    );

    modport slave (
        input  DREQ, dreqSenseLow, rotatingPriority, controllerDisable,
        input  maskReg, HLDA, serviceDone,
`ifdef SOFTWARE_REQUEST_EN
        input  softReqWrite, softReqData,
`endif
        output HRQ, DACK, activeChannel, grantValid, priorityOrder, requestStatus
    );

endinterface
`default_nettype wire

// File: rtl/dma_priority_resolver.sv
`default_nettype none
// ============================================================================
// dma_priority_resolver : combinational winner select; walks the priority
//           order from field [1:0] upward, first requesting channel wins.
// Revision: 1.0
// ============================================================================
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [DMA_CHANNELS-1:0] req,
    input  logic [7:0]              order,
    output logic [DMA_CHANNELS-1:0] winnerOneHot,
    output logic [1:0]              winnerIdx,
    output logic                    anyReq
);

    logic found;

    always_comb begin
        winnerOneHot = '0;
        winnerIdx    = '0;
        found        = 1'b0;
        for (int i = 0; i < DMA_CHANNELS; i++) begin
            if (!found && req[order[2*i +: 2]]) begin
                found        = 1'b1;
                winnerIdx    = order[2*i +: 2];
                winnerOneHot = 4'b0001 << order[2*i +: 2];
            end
        end
    end

    assign anyReq = |req;

endmodule
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// dma_priority_arbiter : DREQ sampling, fixed/rotating priority and HRQ/HLDA
//           handshake for the 4-channel DMA. Optional: SOFTWARE_REQUEST_EN.
// Revision: 1.0
// ============================================================================
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int SYNC_STAGES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    dma_priority_arbiter_if.slave bus
);

    localparam int SYNC_W = SYNC_STAGES * DMA_CHANNELS;

    arbState_t                 state_q, state_d;
    logic [SYNC_W-1:0]         sync_q, sync_d;
    logic [DMA_CHANNELS-1:0]   req_raw, req_s, eff_req;
    logic                      hrq_q, hrq_d;
    logic [DMA_CHANNELS-1:0]   dack_q, dack_d;
    logic [1:0]                active_q, active_d;
    logic                      grant_q, grant_d;
    logic [7:0]                order_q, order_d;
    logic [DMA_CHANNELS-1:0]   status_q, status_d;
    logic [DMA_CHANNELS-1:0]   win_oh;
    logic [1:0]                win_idx;
    logic                      any_req;

    assign req_raw = bus.DREQ ^ {DMA_CHANNELS{bus.dreqSenseLow}};

    // Newest sample enters the low nibble; the top nibble is the synced request.
    if (SYNC_STAGES > 1) begin : g_sync_chain
        assign sync_d = {sync_q[SYNC_W-DMA_CHANNELS-1:0], req_raw};
    end else begin : g_sync_single
        assign sync_d = req_raw;
    end

    assign req_s = sync_q[SYNC_W-1 -: DMA_CHANNELS];

`ifdef SOFTWARE_REQUEST_EN
    logic [DMA_CHANNELS-1:0] soft_q, soft_d;

    // A write to the channel being retired overrides the completion clear.
    always_comb begin
        soft_d = soft_q;
        if (state_q == GRANT && bus.serviceDone) soft_d[active_q] = 1'b0;
        if (bus.softReqWrite) soft_d[bus.softReqData[1:0]] = bus.softReqData[2];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) soft_q <= '0;
        else          soft_q <= soft_d;
    end

    assign eff_req = (req_s & ~bus.maskReg) | soft_q;
`else
    assign eff_req = req_s & ~bus.maskReg;
`endif

    assign status_d = eff_req;

    dma_priority_resolver u_resolver (
        .req          (eff_req),
        .order        (order_q),
        .winnerOneHot (win_oh),
        .winnerIdx    (win_idx),
        .anyReq       (any_req)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            hrq_q    <= 1'b0;
            dack_q   <= '0;
            active_q <= '0;
            grant_q  <= 1'b0;
            order_q  <= DEFAULT_PRIORITY_ORDER;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            order_q  <= order_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (any_req && !bus.controllerDisable) state_d = WAIT_HLDA;
            WAIT_HLDA: begin
                if (!any_req)      state_d = IDLE;
                else if (bus.HLDA) state_d = GRANT;
            end
            GRANT:     if (bus.serviceDone || !bus.HLDA) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Completion takes precedence over an HLDA drop in the same cycle, so it rotates.
    always_comb begin
        hrq_d    = (state_d != IDLE);
        dack_d   = dack_q;
        active_d = active_q;
        grant_d  = grant_q;
        order_d  = bus.rotatingPriority ? order_q : DEFAULT_PRIORITY_ORDER;
        case (state_q)
            WAIT_HLDA: begin
                if (any_req && bus.HLDA) begin
                    dack_d   = win_oh;
                    active_d = win_idx;
                    grant_d  = 1'b1;
                end
            end
            GRANT: begin
                if (bus.serviceDone || !bus.HLDA) begin
                    dack_d  = '0;
                    grant_d = 1'b0;
                end
                if (bus.serviceDone && bus.rotatingPriority) order_d = rotateOrder(active_q);
            end
            default: ;
        endcase
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.activeChannel = active_q;
    assign bus.grantValid    = grant_q;
    assign bus.priorityOrder = order_q;
    assign bus.requestStatus = status_q;

endmodule
`default_nettype wire
